// File: rtl/unit_a_ctrl_if.sv
// -----------------------------------------------------------------------------
// unit_a_ctrl_if
// Bundles the layer-pass control and strobe signals of unit_a_ctrl.
//   start          : one-cycle pulse that launches a layer pass
//   ifm_valid      : upstream pixel valid
//   ifm_ready      : controller accepts a pixel this cycle
//   wm_address     : weight-memory read address
//   wm_enable_read : weight-memory read strobe
//   wm_fifo_enable : weight FIFO shift strobe (read strobe delayed one cycle)
//   fifo_enable    : IFM window FIFO shift strobe (pixel acceptance)
//   conv_enable    : convolution accumulate strobe
//   busy           : a pass is in progress
//   done           : one-cycle completion pulse
// Modport master is the controller; modport slave is its environment.
// -----------------------------------------------------------------------------
interface unit_a_ctrl_if #(
    parameter int ADDRESS_SIZE_WM = 15
) ();
    logic                       start;
    logic                       ifm_valid;
    logic                       ifm_ready;
    logic [ADDRESS_SIZE_WM-1:0] wm_address;
    logic                       wm_enable_read;
    logic                       wm_fifo_enable;
    logic                       fifo_enable;
    logic                       conv_enable;
    logic                       busy;
    logic                       done;

    modport master (
        input  start,
        input  ifm_valid,
        output ifm_ready,
        output wm_address,
        output wm_enable_read,
        output wm_fifo_enable,
        output fifo_enable,
        output conv_enable,
        output busy,
        output done
    );

    modport slave (
        output start,
        output ifm_valid,
        input  ifm_ready,
        input  wm_address,
        input  wm_enable_read,
        input  wm_fifo_enable,
        input  fifo_enable,
        input  conv_enable,
        input  busy,
        input  done
    );
endinterface

// File: rtl/unit_a_ctrl.sv
// -----------------------------------------------------------------------------
// unit_a_ctrl
// Sequencer for one convolution unit. For every filter and every depth slice it
// reads the K*K kernel weights from weight memory (pushing them into the weight
// FIFO one cycle later), then streams the IFM_SIZE*IFM_SIZE input pixels,
// pulsing conv_enable once for every complete KxK window. After the last slice
// of the last filter it drains the convolution pipeline and pulses done.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : unit_a_ctrl_if.master (start/ifm handshake, WM and strobe outputs)
// -----------------------------------------------------------------------------
module unit_a_ctrl #(
    parameter int IFM_SIZE          = 5,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 160,
    parameter int CEIL_DEPTH        = 8,
    parameter int CONV_LATENCY      = 2,
    parameter int ADDRESS_SIZE_WM   = $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS*CEIL_DEPTH)
) (
    input logic              clk,
    input logic              reset,
    unit_a_ctrl_if.master    bus
);

    localparam int KK    = KERNAL_SIZE * KERNAL_SIZE;
    localparam int RD_W  = (KK > 1)                ? $clog2(KK)                : 1;
    localparam int PIX_W = (IFM_SIZE > 1)          ? $clog2(IFM_SIZE)          : 1;
    localparam int SL_W  = (CEIL_DEPTH > 1)        ? $clog2(CEIL_DEPTH)        : 1;
    localparam int FL_W  = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
    localparam int DR_W  = (CONV_LATENCY > 0)      ? $clog2(CONV_LATENCY + 1)  : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_W     = 3'd1,
        LOAD_FLUSH = 3'd2,
        STREAM     = 3'd3,
        DRAIN      = 3'd4,
        DONE       = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic [RD_W-1:0]            read_cnt_q, read_cnt_d;
    logic [PIX_W-1:0]           row_q, row_d;
    logic [PIX_W-1:0]           col_q, col_d;
    logic [SL_W-1:0]            slice_q, slice_d;
    logic [FL_W-1:0]            filt_q, filt_d;
    logic [DR_W-1:0]            drain_q, drain_d;
    logic [ADDRESS_SIZE_WM-1:0] wm_address_q, wm_address_d;

    logic ifm_ready_q, ifm_ready_d;
    logic wm_enable_read_q, wm_enable_read_d;
    logic wm_fifo_enable_q, wm_fifo_enable_d;
    logic conv_enable_q, conv_enable_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic accept_s;
    logic last_slice_s;
    logic last_filt_s;

    // A pixel is taken only while the registered ready is up.
    assign accept_s     = bus.ifm_valid && ifm_ready_q;
    assign last_slice_s = (slice_q == SL_W'(CEIL_DEPTH - 1));
    assign last_filt_s  = (filt_q == FL_W'(NUMBER_OF_FILTERS - 1));

    // Next-state, counter and address computation.
    always_comb begin
        state_d       = state_q;
        read_cnt_d    = read_cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        slice_d       = slice_q;
        filt_d        = filt_q;
        drain_d       = drain_q;
        wm_address_d  = wm_address_q;
        conv_enable_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = LOAD_W;
                    read_cnt_d   = '0;
                    row_d        = '0;
                    col_d        = '0;
                    slice_d      = '0;
                    filt_d       = '0;
                    drain_d      = '0;
                    wm_address_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            LOAD_W: begin
                if (read_cnt_q == RD_W'(KK - 1)) begin
                    read_cnt_d = '0;
                    state_d    = LOAD_FLUSH;
                    // The address advances into the next slice's block, except
                    // after the very last read so it rests on the final weight.
                    if (last_slice_s && last_filt_s) begin
                        wm_address_d = wm_address_q;
                    end else begin
                        wm_address_d = wm_address_q + ADDRESS_SIZE_WM'(1);
                    end
                end else begin
                    read_cnt_d   = read_cnt_q + RD_W'(1);
                    wm_address_d = wm_address_q + ADDRESS_SIZE_WM'(1);
                end
            end

            LOAD_FLUSH: begin
                state_d = STREAM;
            end

            STREAM: begin
                if (accept_s) begin
                    // A full KxK window ends at this pixel.
                    conv_enable_d = (row_q >= PIX_W'(KERNAL_SIZE - 1)) &&
                                    (col_q >= PIX_W'(KERNAL_SIZE - 1));
                    if (col_q == PIX_W'(IFM_SIZE - 1)) begin
                        col_d = '0;
                        if (row_q == PIX_W'(IFM_SIZE - 1)) begin
                            row_d = '0;
                            if (last_slice_s) begin
                                slice_d = '0;
                                if (last_filt_s) begin
                                    filt_d  = filt_q;
                                    state_d = DRAIN;
                                end else begin
                                    filt_d  = filt_q + FL_W'(1);
                                    state_d = LOAD_W;
                                end
                            end else begin
                                slice_d = slice_q + SL_W'(1);
                                state_d = LOAD_W;
                            end
                        end else begin
                            row_d = row_q + PIX_W'(1);
                        end
                    end else begin
                        col_d = col_q + PIX_W'(1);
                    end
                end else begin
                    state_d = STREAM;
                end
            end

            DRAIN: begin
                if (drain_q == DR_W'(CONV_LATENCY)) begin
                    drain_d = '0;
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output strobes decoded from the next state so the registered outputs
    // line up with the state they belong to.
    always_comb begin
        ifm_ready_d      = (state_d == STREAM);
        wm_enable_read_d = (state_d == LOAD_W);
        wm_fifo_enable_d = wm_enable_read_q;
        busy_d           = (state_d == LOAD_W) || (state_d == LOAD_FLUSH) ||
                           (state_d == STREAM) || (state_d == DRAIN);
        done_d           = (state_d == DONE);
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            read_cnt_q       <= '0;
            row_q            <= '0;
            col_q            <= '0;
            slice_q          <= '0;
            filt_q           <= '0;
            drain_q          <= '0;
            wm_address_q     <= '0;
            ifm_ready_q      <= 1'b0;
            wm_enable_read_q <= 1'b0;
            wm_fifo_enable_q <= 1'b0;
            conv_enable_q    <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            read_cnt_q       <= read_cnt_d;
            row_q            <= row_d;
            col_q            <= col_d;
            slice_q          <= slice_d;
            filt_q           <= filt_d;
            drain_q          <= drain_d;
            wm_address_q     <= wm_address_d;
            ifm_ready_q      <= ifm_ready_d;
            wm_enable_read_q <= wm_enable_read_d;
            wm_fifo_enable_q <= wm_fifo_enable_d;
            conv_enable_q    <= conv_enable_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign bus.ifm_ready      = ifm_ready_q;
    assign bus.wm_address     = wm_address_q;
    assign bus.wm_enable_read = wm_enable_read_q;
    assign bus.wm_fifo_enable = wm_fifo_enable_q;
    assign bus.fifo_enable    = accept_s;
    assign bus.conv_enable    = conv_enable_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_unit_a_ctrl.sv
// -----------------------------------------------------------------------------
// tb_unit_a_ctrl
// Scoreboard bench for unit_a_ctrl with a reduced configuration. At each start
// the expected pass is pushed as an ordered token list: K*K weight reads with
// their addresses per slice, then one token per pixel saying whether that
// pixel completes a window. A monitor on the falling edge pops tokens as the
// DUT reads weights or accepts pixels and checks strobes, ordering and timing.
// -----------------------------------------------------------------------------
module tb_unit_a_ctrl;

    localparam int N  = 7;
    localparam int K  = 3;
    localparam int F  = 2;
    localparam int D  = 2;
    localparam int CL = 2;
    localparam int AW = $clog2(K*K*F*D);

    typedef struct {
        bit is_read;
        int val;
    } tok_t;

    logic clk;
    logic reset;

    unit_a_ctrl_if #(.ADDRESS_SIZE_WM(AW)) u_if ();

    unit_a_ctrl #(
        .IFM_SIZE          (N),
        .KERNAL_SIZE       (K),
        .NUMBER_OF_FILTERS (F),
        .CEIL_DEPTH        (D),
        .CONV_LATENCY      (CL),
        .ADDRESS_SIZE_WM   (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.master)
    );

    tok_t tok_q[$];
    int   checks;
    int   errors;
    int   done_cnt;
    int   conv_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected token stream for one complete pass, straight from the rules.
    task automatic build_tokens();
        tok_t t;
        tok_q.delete();
        for (int f = 0; f < F; f++) begin
            for (int s = 0; s < D; s++) begin
                for (int i = 0; i < K*K; i++) begin
                    t.is_read = 1'b1;
                    t.val     = (f*D + s)*K*K + i;
                    tok_q.push_back(t);
                end
                for (int p = 0; p < N*N; p++) begin
                    t.is_read = 1'b0;
                    t.val     = ((p / N) >= K-1 && (p % N) >= K-1) ? 1 : 0;
                    tok_q.push_back(t);
                end
            end
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        int   cyc;
        int   last_read_cyc;
        int   last_pix_cyc;
        bit   prev_rd;
        bit   prev_ready;
        bit   exp_conv;
        tok_t t;
        cyc = 0; last_read_cyc = -100; last_pix_cyc = -100;
        prev_rd = 1'b0; prev_ready = 1'b0; exp_conv = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                prev_rd    = 1'b0;
                prev_ready = 1'b0;
                exp_conv   = 1'b0;
            end else begin
                chk("conv_enable", u_if.conv_enable, exp_conv);
                if (u_if.conv_enable) conv_seen++;
                chk("fifo_enable", u_if.fifo_enable, u_if.ifm_valid && u_if.ifm_ready);
                chk("wm_fifo_lag", u_if.wm_fifo_enable, prev_rd);
                if (u_if.wm_enable_read) begin
                    chk("busy_in_load", u_if.busy, 1);
                    chk("ready_in_load", u_if.ifm_ready, 0);
                    if (tok_q.size() == 0 || !tok_q[0].is_read) begin
                        chk("unexpected_read", 1, 0);
                    end else begin
                        t = tok_q.pop_front();
                        chk("wm_address", u_if.wm_address, t.val);
                    end
                    last_read_cyc = cyc;
                end
                if (u_if.ifm_ready && !prev_ready) begin
                    chk("flush_gap", cyc - last_read_cyc, 2);
                end
                if (u_if.ifm_ready) begin
                    chk("busy_in_stream", u_if.busy, 1);
                    if (tok_q.size() == 0 || tok_q[0].is_read) begin
                        chk("ready_without_pixel_due", 1, 0);
                    end
                end
                exp_conv = 1'b0;
                if (u_if.fifo_enable) begin
                    if (tok_q.size() == 0 || tok_q[0].is_read) begin
                        chk("unexpected_accept", 1, 0);
                    end else begin
                        t = tok_q.pop_front();
                        exp_conv = (t.val != 0);
                    end
                    last_pix_cyc = cyc;
                end
                if (u_if.done) begin
                    chk("done_tokens_left", tok_q.size(), 0);
                    chk("done_latency", cyc - last_pix_cyc, CL + 2);
                    chk("busy_at_done", u_if.busy, 0);
                    done_cnt++;
                end
                prev_rd    = u_if.wm_enable_read;
                prev_ready = u_if.ifm_ready;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ifm_ready"},      u_if.ifm_ready, 0);
        chk({tag, "_wm_address"},     u_if.wm_address, 0);
        chk({tag, "_wm_enable_read"}, u_if.wm_enable_read, 0);
        chk({tag, "_wm_fifo_enable"}, u_if.wm_fifo_enable, 0);
        chk({tag, "_fifo_enable"},    u_if.fifo_enable, 0);
        chk({tag, "_conv_enable"},    u_if.conv_enable, 0);
        chk({tag, "_busy"},           u_if.busy, 0);
        chk({tag, "_done"},           u_if.done, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 u_if.start = 1'b1;
        @(posedge clk); #1 u_if.start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", u_if.busy, 1);
        chk("first_read_strobe", u_if.wm_enable_read, 1);
        chk("first_read_addr", u_if.wm_address, 0);
    endtask

    // mode 0: valid always high, 1: alternating 1/0, 2: random with stray starts.
    task automatic run_pass(input int mode);
        int base;
        bit ok;
        build_tokens();
        conv_seen = 0;
        base = done_cnt;
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            @(posedge clk); #1;
            case (mode)
                0:       u_if.ifm_valid = 1'b1;
                1:       u_if.ifm_valid = ~u_if.ifm_valid;
                default: u_if.ifm_valid = ($urandom_range(0, 99) < 60);
            endcase
            u_if.start = (mode == 2) && (tok_q.size() > 0) && ($urandom_range(0, 29) == 0);
            if (done_cnt != base) ok = 1'b1;
        end
        u_if.start     = 1'b0;
        u_if.ifm_valid = 1'b0;
        chk("pass_completed", ok, 1);
        chk("done_pulses", done_cnt - base, 1);
        chk("conv_count", conv_seen, F*D*(N-K+1)*(N-K+1));
        @(negedge clk);
        chk("final_address", u_if.wm_address, F*D*K*K - 1);
        chk("idle_busy", u_if.busy, 0);
        chk("idle_done", u_if.done, 0);
    endtask

    initial begin
        checks = 0; errors = 0; done_cnt = 0; conv_seen = 0;
        reset = 1'b0;
        u_if.start = 1'b0;
        u_if.ifm_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("idle");

        run_pass(0);
        run_pass(1);
        run_pass(2);

        // Reset in the middle of streaming.
        build_tokens();
        pulse_start();
        u_if.ifm_valid = 1'b1;
        for (int c = 0; c < 200 && !u_if.ifm_ready; c++) @(negedge clk);
        chk("reached_stream", u_if.ifm_ready, 1);
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tok_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        u_if.ifm_valid = 1'b0;
        check_all_zero("no_resume");

        run_pass(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
